// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Cache-side and memory-side signal bundle of the memory port arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int LINE_WORDS = 4,
    parameter int WIDX_W     = $clog2(LINE_WORDS)
);
    logic              ic_req;
    logic [31:0]       ic_addr;
    logic [31:0]       ic_rdata;
    logic              ic_rvalid;
    logic              ic_done;
    logic              dc_req;
    logic              dc_we;
    logic [31:0]       dc_addr;
    logic [31:0]       dc_wdata;
    logic [31:0]       dc_rdata;
    logic              dc_rvalid;
    logic              dc_done;
    logic [WIDX_W-1:0] word_idx;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    // Arbiter side: owns the memory port and answers both caches.
    modport master (
        input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
        output ic_rdata, ic_rvalid, ic_done, dc_rdata, dc_rvalid, dc_done,
        output word_idx, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Environment side: the two caches plus the memory model.
    modport slave (
        output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, mem_rdata, mem_ready,
        input  ic_rdata, ic_rvalid, ic_done, dc_rdata, dc_rvalid, dc_done,
        input  word_idx, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Round-robin share of one memory word port between icache and
//             dcache, running a full line burst for the granted owner.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int LINE_WORDS = 4,
    parameter int WIDX_W     = $clog2(LINE_WORDS)
) (
    input  logic                clock,
    input  logic                reset,
    mem_port_arbiter_if.master  bus
);
    localparam logic [1:0]        c_IDLE    = 2'd0;
    localparam logic [1:0]        c_BURST_I = 2'd1;
    localparam logic [1:0]        c_BURST_D = 2'd2;
    localparam logic              c_ICACHE  = 1'b0;
    localparam logic              c_DCACHE  = 1'b1;
    localparam logic [31:0]       c_LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
    localparam logic [WIDX_W-1:0] c_LAST_IDX  = WIDX_W'(LINE_WORDS - 1);

    logic [1:0]        r_state;
    logic [WIDX_W-1:0] r_cnt;
    logic [31:0]       r_base;
    logic              r_we;
    logic              r_last_grant;

    logic w_burst;
    logic w_grant_i;
    logic w_grant_d;
    logic w_beat;
    logic w_last;

    assign w_burst   = (r_state == c_BURST_I) || (r_state == c_BURST_D);
    // On a tie the cache that did not win last time gets the port.
    assign w_grant_d = (r_state == c_IDLE) && bus.dc_req &&
                       (!bus.ic_req || (r_last_grant == c_ICACHE));
    assign w_grant_i = (r_state == c_IDLE) && bus.ic_req && !w_grant_d;
    assign w_beat    = w_burst && bus.mem_ready;
    assign w_last    = (r_cnt == c_LAST_IDX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_base       <= '0;
            r_we         <= 1'b0;
            r_last_grant <= c_ICACHE;
        end else if (w_grant_d) begin
            r_state      <= c_BURST_D;
            r_cnt        <= '0;
            r_base       <= bus.dc_addr & c_LINE_MASK;
            r_we         <= bus.dc_we;
            r_last_grant <= c_DCACHE;
        end else if (w_grant_i) begin
            r_state      <= c_BURST_I;
            r_cnt        <= '0;
            r_base       <= bus.ic_addr & c_LINE_MASK;
            r_we         <= 1'b0;
            r_last_grant <= c_ICACHE;
        end else if (w_beat) begin
            r_cnt <= r_cnt + WIDX_W'(1);
            if (w_last) begin
                r_state <= c_IDLE;
            end
        end
    end

    assign bus.mem_req   = w_burst;
    assign bus.mem_we    = w_burst && r_we;
    assign bus.word_idx  = w_burst ? r_cnt : '0;
    assign bus.mem_addr  = w_burst ? (r_base + {{(30 - WIDX_W){1'b0}}, r_cnt, 2'b00}) : 32'd0;
    assign bus.mem_wdata = (w_burst && r_we) ? bus.dc_wdata : 32'd0;

    assign bus.ic_rdata  = bus.mem_rdata;
    assign bus.dc_rdata  = bus.mem_rdata;
    // Valid/done follow mem_ready combinationally, and only for the owner.
    assign bus.ic_rvalid = (r_state == c_BURST_I) && bus.mem_ready && !r_we;
    assign bus.ic_done   = (r_state == c_BURST_I) && bus.mem_ready && w_last;
    assign bus.dc_rvalid = (r_state == c_BURST_D) && bus.mem_ready && !r_we;
    assign bus.dc_done   = (r_state == c_BURST_D) && bus.mem_ready && w_last;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single main-memory word port between the instruction-cache refill path and the data-cache miss/write-back path. Grants one cache at a time, then runs a full cache-line burst of `LINE_WORDS` single-word memory transactions on its behalf. Returns read words to the owner and pulls write data from it word by word. Sits between `icache`/dcache and the memory model; the fetch and memory stages stay stalled by their caches until the matching `*_done` pulse.

## Interface

Parameters:

- `LINE_WORDS`, 4: words per cache line; power of two, 2..16.
- `WIDX_W`, `$clog2(LINE_WORDS)`: word-index width.

Ports:

- `clock`  input  1  system clock, all state on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `ic_req`  input  1  icache line-read request; held until `ic_done`.
- `ic_addr`  input  32  icache line address; low `log2(LINE_WORDS*4)` bits are ignored.
- `ic_rdata`  output  32  read word for the icache (= `mem_rdata`).
- `ic_rvalid`  output  1  `ic_rdata` valid this cycle.
- `ic_done`  output  1  last word of the icache burst, this cycle.
- `dc_req`  input  1  dcache request; held until `dc_done`.
- `dc_we`  input  1  1 = line write-back, 0 = line read; sampled at grant.
- `dc_addr`  input  32  dcache line address; low bits are ignored.
- `dc_wdata`  input  32  write word selected by `word_idx`; combinational from the dcache.
- `dc_rdata`  output  32  read word for the dcache (= `mem_rdata`).
- `dc_rvalid`  output  1  `dc_rdata` valid this cycle.
- `dc_done`  output  1  last word of the dcache burst, this cycle.
- `word_idx`  output  WIDX_W  index of the word currently on the memory port.
- `mem_req`  output  1  memory transaction active.
- `mem_we`  output  1  memory write.
- `mem_addr`  output  32  word address.
- `mem_wdata`  output  32  write data (= `dc_wdata` during a write burst).
- `mem_rdata`  input  32  read data, valid with `mem_ready`.
- `mem_ready`  input  1  current word complete, this cycle.

## Operation

- **States:** `IDLE`, `BURST_I`, `BURST_D`.
- **Arbitration in `IDLE`:**
  - One requester only: it wins.
  - Both requesting: the one not in `last_grant` wins (round-robin).
  - `last_grant` resets to ICACHE, so dcache wins the first tie.
- **On grant:**
  - Latch the line-aligned address into `base`.
  - Latch `dc_we` into `we_q`; `we_q` is 0 for icache.
  - Clear the word counter.
  - Update `last_grant`.
  - Enter `BURST_I` or `BURST_D`.
- **In a BURST state:**
  - `mem_req` = 1.
  - `mem_addr` = `base + {word_idx, 2'b00}`, modulo 2^32.
  - `mem_we` = `we_q`.
  - `mem_wdata` = `dc_wdata`.
- **Each cycle with `mem_ready` = 1:**
  - The owner's `*_rvalid` = `!we_q`.
  - The word counter increments.
  - When the counter is at `LINE_WORDS-1`, the owner's `*_done` = 1 and the next state is `IDLE`.
- **Valid and done are combinational from `mem_ready`:** `*_rvalid` and `*_done` are only ever asserted for the current owner. A write burst gives `dc_done` with `dc_rvalid` = 0.
- **Request drop:** a requester that drops `*_req` mid-burst does not abort the burst; the burst runs to completion.
- **`mem_ready` outside a burst** is ignored.

## Timing

- **Reset values:**
  - State `IDLE`; counter 0; `base` 0; `we_q` 0; `last_grant` ICACHE.
  - All outputs 0: `mem_req`, `mem_we`, `mem_addr`, `word_idx`, every `*_rvalid` and every `*_done`.
- **Grant latency:** a request seen in `IDLE` at edge N puts `mem_req` = 1 from edge N+1.
- **Burst length:** exactly `LINE_WORDS` `mem_ready` cycles; zero-wait memory takes `LINE_WORDS` cycles.
- **Gap after a burst:** the cycle after a done is always `IDLE`, with `mem_req` = 0 for at least 1 cycle.
  - The requester must drop `*_req` on the edge ending its done cycle.
  - A `*_req` still high in `IDLE` starts a new burst.
- **Simultaneous requests:** a new request arriving during a burst waits; it is arbitrated in the next `IDLE` cycle.
- **Reset mid-burst:** immediate return to reset values; the partial burst is discarded and no done is issued.
- **Address wrap:** a line at 0xFFFFFFF0 with `LINE_WORDS` = 4 gives word addresses F0, F4, F8, FC; the address wraps modulo 2^32 with no error.

## Test plan

- Reset release, then `ic_req` with `ic_addr` = 0x104, `mem_ready` tied 1 -> `mem_addr` is 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles. `ic_rvalid` on all 4; `ic_done` on the 4th only; `mem_req` low the next cycle.
- `ic_req` and `dc_req` (read, 0x2000) rise in the same cycle after reset -> dcache burst first. Then 1 `IDLE` cycle, then the icache burst; `last_grant` ends at ICACHE.
- Dcache write-back to 0x3000; dcache drives `dc_wdata` = 0xA0 + `word_idx`; `mem_ready` pattern 1,0,0,1,1,0,1 -> writes 0xA0..0xA3 to 0x3000..0x300C. `mem_we` = 1 throughout, `dc_rvalid` never set, `dc_done` on the 7th cycle.
- Both requesters held high for 4 bursts -> grants alternate D, I, D, I, with 1 idle cycle between bursts.
- Assert `reset` low after 2 words of an icache burst -> `mem_req` = 0 immediately; `ic_done` never pulses. After release, the next request starts at word 0.
- Line address 0xFFFFFFF0, `LINE_WORDS` = 4 -> `mem_addr` = 0xFFFFFFF0, F4, F8, FC, then `done`.
